// File: rtl/pb_debouncer.sv
// rtl/pb_debouncer.sv - push-button synchronizer and debouncer with edge strobes
// A level change is accepted only after the synchronized input holds it for STABLE_CYCLES clocks.
module pb_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  output logic pb_clean,
  output logic pb_rise,
  output logic pb_fall,
  output logic busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pb_raw};
    end
  end

  // pb_clean and busy are rewritten on every transition so they always track the state encoding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE_LOW;
      cnt      <= '0;
      pb_clean <= 1'b0;
      pb_rise  <= 1'b0;
      pb_fall  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      pb_rise <= 1'b0;
      pb_fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          pb_clean <= 1'b0;
          if (s) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt  <= '0;
            busy <= 1'b0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state    <= IDLE_LOW;
            cnt      <= '0;
            pb_clean <= 1'b0;
            busy     <= 1'b0;
          end else if (cnt >= CNT_LAST) begin
            state    <= IDLE_HIGH;
            cnt      <= '0;
            pb_clean <= 1'b1;
            pb_rise  <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt      <= cnt + CNT_ONE;
            pb_clean <= 1'b0;
            busy     <= 1'b1;
          end
        end
        IDLE_HIGH: begin
          pb_clean <= 1'b1;
          if (!s) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt  <= '0;
            busy <= 1'b0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state    <= IDLE_HIGH;
            cnt      <= '0;
            pb_clean <= 1'b1;
            busy     <= 1'b0;
          end else if (cnt >= CNT_LAST) begin
            state    <= IDLE_LOW;
            cnt      <= '0;
            pb_clean <= 1'b0;
            pb_fall  <= 1'b1;
            busy     <= 1'b0;
          end else begin
            cnt      <= cnt + CNT_ONE;
            pb_clean <= 1'b1;
            busy     <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE_LOW;
          cnt      <= '0;
          pb_clean <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pb_debouncer.md
# pb_debouncer

Push-button conditioning stage that sits directly upstream of the one-pulser. It synchronizes the raw asynchronous button input into the `clk` domain and rejects contact bounce. `pb_clean` changes only after the synchronized input has held its new level for `STABLE_CYCLES` consecutive clocks. `pb_clean` drives the one-pulser's `clkPB` input; single-cycle edge strobes are also provided for other consumers.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `pb_raw`. Legal range is ≥2.
- `STABLE_CYCLES`, default 16: consecutive agreeing samples required to accept a level change. Legal range is ≥2. The counter is `$clog2(STABLE_CYCLES)` bits wide.
- `clk` input, 1 bit: single system clock; all logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `pb_raw` input, 1 bit: raw push-button level, asynchronous and bouncy; active-high.
- `pb_clean` output, 1 bit: debounced level, registered; feeds the one-pulser's `clkPB`.
- `pb_rise` output, 1 bit: one-cycle strobe, high in the same cycle `pb_clean` first reads 1.
- `pb_fall` output, 1 bit: one-cycle strobe, high in the same cycle `pb_clean` first reads 0.
- `busy` output, 1 bit: high while a candidate level change is being timed (WAIT states).

## Operation
- Synchronizer:
  - `SYNC_STAGES` flops in series; `s` is the last flop's output.
  - No other logic reads `pb_raw`.
- FSM states: `IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH`, `WAIT_LOW`. `cnt` is the stability counter.
- `IDLE_LOW`:
  - `s`=1 → `WAIT_HIGH`, `cnt`=1.
  - Otherwise stay, `cnt`=0.
- `WAIT_HIGH`:
  - `s`=0 → `IDLE_LOW`, `cnt`=0. Bounce is rejected and no output changes.
  - `s`=1 and `cnt`==`STABLE_CYCLES`-1 → `IDLE_HIGH`, `pb_clean`←1, `pb_rise`←1, `cnt`=0.
  - `s`=1 otherwise → `cnt`+1.
- `IDLE_HIGH` / `WAIT_LOW`: mirror image of the two states above. Commit sets `pb_clean`←0 and `pb_fall`←1.
- Encoding rules:
  - `pb_clean` is 1 exactly in `IDLE_HIGH` and `WAIT_LOW`.
  - `busy` is 1 exactly in `WAIT_HIGH` and `WAIT_LOW`.
- Strobes:
  - `pb_rise` and `pb_fall` are registered and deassert on the following edge.
  - They are never high together and never high for two consecutive cycles.
- Counter safety:
  - `cnt` never exceeds `STABLE_CYCLES`-1 and never wraps.
  - Any out-of-range or illegal state encoding recovers to `IDLE_LOW` on the next edge.

## Timing
- Reset: on any edge with `rst`=1:
  - All synchronizer flops are 0 and `cnt` is 0.
  - State is `IDLE_LOW`.
  - `pb_clean`, `pb_rise`, `pb_fall`, and `busy` are all 0.
  - `rst` has priority over every other event.
- Acceptance latency:
  - Let edge 0 be the first rising edge at which `pb_raw` shows the new level, and assume `pb_raw` is held stable.
  - The commit happens at edge `SYNC_STAGES`+`STABLE_CYCLES`-1.
  - `pb_clean` and the matching strobe are therefore visible after `SYNC_STAGES`+`STABLE_CYCLES` edges: 18 with defaults, 6 with `SYNC_STAGES`=2, `STABLE_CYCLES`=4.
- `busy` timing: rises at edge `SYNC_STAGES` and falls at the commit edge.
- Rejection:
  - Any excursion of `s` shorter than `STABLE_CYCLES` cycles produces no change on `pb_clean` and no strobe.
  - Each return to the old level restarts the count from zero.
- Reset mid-WAIT: the partial count is discarded.
  - If `pb_raw` is held high through reset, `pb_clean` rises after the full latency measured from the first edge with `rst`=0.
- Throughput: the minimum spacing between a `pb_rise` and the next `pb_fall` is `STABLE_CYCLES` cycles.

## Test plan
All scenarios use `SYNC_STAGES`=2, `STABLE_CYCLES`=4, a 2 ns clock, and check every cycle.

- Reset: `rst`=1 for 5 edges with `pb_raw`=1 → all outputs 0 during reset. After release, `pb_clean` rises on the 6th edge with `rst`=0; `pb_rise` is high for exactly that one cycle.
- Clean press/release: `pb_raw` 0→1 held for 20 cycles, then 1→0 held.
  - On the press: `pb_clean` 1 after 6 edges, one `pb_rise` pulse, `pb_fall`=0 throughout.
  - On the release: `pb_clean` 0 after 6 edges, one `pb_fall` pulse.
- Bounce: `pb_raw` = high 3 cycles, low 1, high 2, low 1, then held high.
  - `pb_clean` rises exactly 6 edges after the final low→high transition.
  - Exactly one `pb_rise` pulse; `busy` toggles on every bounce.
- Glitch rejection: isolated 3-cycle high pulse on `pb_raw` → `pb_clean`, `pb_rise`, and `pb_fall` stay 0; `busy` high for 3 cycles then 0.
- Reset mid-count: `pb_raw` held high, `rst` pulsed for 1 edge while `busy`=1.
  - Outputs go to 0 at that edge.
  - `pb_clean` rises 6 edges after `rst` returns to 0.
- Chain check: `pb_debouncer` instantiated driving the one-pulser, with a bouncy press applied → exactly one `clk_en` pulse per accepted press.
